// File: rtl/dm_sized_if.sv
// rtl/dm_sized_if.sv - request/response bundle between the CPU control unit and dm_sized
// Purpose: groups the data memory handshake, access fields and results.
// Ports (modports):
//   master - drives req, mem_write, size, load_unsigned, address, data_in;
//            observes busy, done, data_out, err
//   slave  - the memory side of the same signals
interface dm_sized_if;
    logic        req;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
    logic        err;

    modport master (
        output req, mem_write, size, load_unsigned, address, data_in,
        input  busy, done, data_out, err
    );

    modport slave (
        input  req, mem_write, size, load_unsigned, address, data_in,
        output busy, done, data_out, err
    );
endinterface

// File: rtl/dm_sized.sv
// rtl/dm_sized.sv - byte/half/word data memory with req/busy/done handshake and access latency
// Purpose: DEPTH x 32-bit data memory. Byte-lane stores, sign/zero-extended loads,
//          misaligned/illegal-size accesses flagged on err instead of touching memory.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous active-high reset; aborts any access in flight
//   bus   - dm_sized_if.slave: req/mem_write/size/load_unsigned/address/data_in in,
//           busy/done/data_out/err out
// Parameters: DEPTH (words, power of two >= 4), LATENCY (1..15 edges accept-to-done)
// Optional feature: DM_ZERO_INIT_EN - after reset, sweep the array to zero (CLEAR state),
//                   one word per cycle, busy held high until the sweep ends.
module dm_sized #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic      clock,
    input  logic      reset,
    dm_sized_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2
`ifdef DM_ZERO_INIT_EN
        ,S_CLEAR = 2'd3
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           wr_q, wr_d;
    logic [1:0]     size_q, size_d;
    logic           uns_q, uns_d;
    logic [AW+1:0]  addr_q, addr_d;
    logic [31:0]    din_q, din_d;
    logic [31:0]    dout_q, dout_d;
    logic           err_q, err_d;
`ifdef DM_ZERO_INIT_EN
    logic [AW-1:0]  clr_q, clr_d;
`endif

    logic [31:0]    mem_q [DEPTH];

    // With LATENCY=1 the access completes on the accepting edge itself, so the
    // fields have not been latched yet; take them straight from the bus in IDLE.
    logic           acc_wr, acc_uns, acc_bad, enter_done, commit;
    logic [1:0]     acc_size;
    logic [AW+1:0]  acc_addr;
    logic [31:0]    acc_din, rd_word, shifted, load_val, wdata;
    logic [3:0]     be;

    always_comb begin
        if (state_q == S_IDLE) begin
            acc_wr   = bus.mem_write;
            acc_size = bus.size;
            acc_uns  = bus.load_unsigned;
            acc_addr = bus.address[AW+1:0];
            acc_din  = bus.data_in;
        end else begin
            acc_wr   = wr_q;
            acc_size = size_q;
            acc_uns  = uns_q;
            acc_addr = addr_q;
            acc_din  = din_q;
        end
    end

    always_comb begin
        acc_bad  = (acc_size == 2'b11)
                 || ((acc_size == 2'b01) && acc_addr[0])
                 || ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00));
        rd_word  = mem_q[acc_addr[AW+1:2]];
        shifted  = rd_word >> {acc_addr[1:0], 3'b000};
        be       = 4'b0000;
        wdata    = acc_din;
        load_val = rd_word;
        case (acc_size)
            2'b00: begin
                be       = 4'b0001 << acc_addr[1:0];
                wdata    = {4{acc_din[7:0]}};
                load_val = acc_uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                be       = acc_addr[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{acc_din[15:0]}};
                load_val = acc_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dout_d  = dout_q;
        err_d   = 1'b0;
`ifdef DM_ZERO_INIT_EN
        clr_d   = clr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    wr_d   = bus.mem_write;
                    size_d = bus.size;
                    uns_d  = bus.load_unsigned;
                    addr_d = bus.address[AW+1:0];
                    din_d  = bus.data_in;
                    if (LATENCY == 1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
`ifdef DM_ZERO_INIT_EN
            S_CLEAR: begin
                if (clr_q == AW'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        enter_done = (state_d == S_DONE) && (state_q != S_DONE);
        if (enter_done) begin
            err_d = acc_bad;
            if (!acc_bad && !acc_wr) begin
                dout_d = load_val;
            end
        end
    end

    // The array block has no reset, so suppress the write explicitly while reset is high.
    assign commit = enter_done && acc_wr && !acc_bad && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
`ifdef DM_ZERO_INIT_EN
            state_q <= S_CLEAR;
            clr_q   <= '0;
`else
            state_q <= S_IDLE;
`endif
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
`ifdef DM_ZERO_INIT_EN
            clr_q   <= clr_d;
`endif
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (commit && be[b]) begin
                mem_q[acc_addr[AW+1:2]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
`ifdef DM_ZERO_INIT_EN
        if ((state_q == S_CLEAR) && !reset) begin
            mem_q[clr_q] <= '0;
        end
`endif
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.data_out = dout_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_dm_sized.sv
// tb/tb_dm_sized.sv - directed self-checking bench for dm_sized (DEPTH=1024, LATENCY=2)
module tb_dm_sized;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total  = 0;
    int   passed = 0;

    dm_sized_if bus ();

    dm_sized #(.DEPTH(1024), .LATENCY(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (!bus.busy) return;
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    // One access: accepted on the first posedge after the request is driven.
    task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int bcy, output logic e);
        wait_idle();
        bus.req = 1'b1; bus.mem_write = wr; bus.size = sz;
        bus.load_unsigned = uns; bus.address = a; bus.data_in = d;
        @(posedge clock); #1;
        bus.req = 1'b0;
        lat = -1; bcy = 0; e = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            if (bus.busy) bcy++;
            if (bus.done) begin
                lat = k;
                e = bus.err;
                break;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic run(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d, input logic exp_err);
        int lat, bcy;
        logic e;
        access(wr, sz, uns, a, d, lat, bcy, e);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] exp);
        run(tag, 1'b0, sz, uns, a, 32'd0, 1'b0);
        check({tag, "_data"}, bus.data_out, exp);
    endtask

    initial begin
        int lat, bcy, dcnt, ccnt;
        logic e;
        bus.req = 1'b0; bus.mem_write = 1'b0; bus.size = 2'b10;
        bus.load_unsigned = 1'b0; bus.address = '0; bus.data_in = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
`ifdef DM_ZERO_INIT_EN
        check("rst_busy", {31'd0, bus.busy}, 32'd1);
`else
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
`endif
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_dout", bus.data_out, 32'd0);
        @(negedge clock); reset = 1'b0;
`ifdef DM_ZERO_INIT_EN
        ccnt = 0;
        for (int k = 0; k < 1100 && bus.busy; k++) begin
            @(posedge clock); #1;
            ccnt++;
        end
        check("clear_cycles", 32'(ccnt), 32'd1024);
        load("clear_rd", 2'b10, 1'b0, 32'h0000_0ABC, 32'h0);
`else
        @(posedge clock); #1;
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
`endif

        // Word store then word load, with latency and busy duration
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, bcy, e);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_busy", 32'(bcy), 32'd2);
        check("sw_err", {31'd0, e}, 32'd0);
        check("sw_dout_kept", bus.data_out, 32'd0);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, lat, bcy, e);
        check("lw_lat", 32'(lat), 32'd2);
        check("lw_busy", 32'(bcy), 32'd2);
        check("lw_data", bus.data_out, 32'hDEAD_BEEF);

        // Byte store into lane 3, signed and unsigned byte loads
        run("sw2", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 1'b0);
        run("sb", 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080, 1'b0);
        load("lw_sb", 2'b10, 1'b0, 32'h10, 32'h8022_3344);
        load("lb", 2'b00, 1'b0, 32'h13, 32'hFFFF_FF80);
        load("lbu", 2'b00, 1'b1, 32'h13, 32'h0000_0080);
        load("lbu1", 2'b00, 1'b1, 32'h11, 32'h0000_0033);

        // Halfword store into upper half, signed and unsigned half loads
        run("sw0", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        run("sh", 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF, 1'b0);
        load("lw_sh", 2'b10, 1'b0, 32'h20, 32'hBEEF_0000);
        load("lh", 2'b01, 1'b0, 32'h22, 32'hFFFF_BEEF);
        load("lhu", 2'b01, 1'b1, 32'h22, 32'h0000_BEEF);
        load("lbu_hi", 2'b00, 1'b1, 32'h23, 32'h0000_00BE);
        load("lh_lo", 2'b01, 1'b0, 32'h20, 32'h0000_0000);

        // Error cases: memory and data_out untouched
        run("sw4", 1'b1, 2'b10, 1'b0, 32'h04, 32'h1234_5678, 1'b0);
        load("lw_ref", 2'b10, 1'b0, 32'h10, 32'h8022_3344);
        run("sw_mis", 1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFF_FFFF, 1'b1);
        check("sw_mis_dout", bus.data_out, 32'h8022_3344);
        run("ld_ill", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1'b1);
        check("ld_ill_dout", bus.data_out, 32'h8022_3344);
        run("lh_mis", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b1);
        check("lh_mis_dout", bus.data_out, 32'h8022_3344);
        @(posedge clock); #1;
        check("err_pulse", {31'd0, bus.err}, 32'd0);
        load("lw4_kept", 2'b10, 1'b0, 32'h04, 32'h1234_5678);

        // req held high: one acceptance per three cycles, 0x1010 aliases 0x0010
        wait_idle();
        dcnt = 0;
        for (int i = 0; i < 9; i++) begin
            if (i != 0) @(negedge clock);
            bus.req = 1'b1; bus.mem_write = 1'b1; bus.size = 2'b10;
            bus.address = (i % 2 == 0) ? 32'h1010 : 32'h14;
            bus.data_in = 32'hA000_0000 + 32'(i);
            @(posedge clock); #1;
            if (bus.done) dcnt++;
        end
        bus.req = 1'b0;
        check("held_dones", 32'(dcnt), 32'd3);
        load("alias_10", 2'b10, 1'b0, 32'h10, 32'hA000_0006);
        load("alias_14", 2'b10, 1'b0, 32'h14, 32'hA000_0003);
        load("alias_1010", 2'b10, 1'b0, 32'h1010, 32'hA000_0006);

        // Reset during WAIT of a store aborts it
        run("sw30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h0BAD_F00D, 1'b0);
        wait_idle();
        bus.req = 1'b1; bus.mem_write = 1'b1; bus.size = 2'b10;
        bus.address = 32'h30; bus.data_in = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        bus.req = 1'b0;
        check("wait_busy", {31'd0, bus.busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_dout", bus.data_out, 32'd0);
        repeat (2) begin
            @(posedge clock); #1;
            check("abort_err", {31'd0, bus.err}, 32'd0);
        end
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        check("post_abort_done", {31'd0, bus.done}, 32'd0);
`ifdef DM_ZERO_INIT_EN
        load("abort_rd", 2'b10, 1'b0, 32'h30, 32'h0);
`else
        load("abort_rd", 2'b10, 1'b0, 32'h30, 32'h0BAD_F00D);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dm_sized.md
Name: dm_sized

Overview:
- Parametrised next-generation data memory for the single-cycle/multi-cycle CPU datapath.
- Supports byte, halfword and word accesses with byte-lane writes and sign/zero-extended loads.
- Has a req/busy/done handshake with configurable access latency, so the control unit can stall on memory.
- Flags misaligned or illegal-size accesses instead of silently corrupting memory.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two ≥ 4.
- LATENCY, 1, clock edges from request acceptance to done; legal range 1..15.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  access request; sampled only when busy=0.
- mem_write  input  1  1=store, 0=load; sampled with req.
- size  input  2  00=byte, 01=halfword, 10=word, 11=illegal.
- load_unsigned  input  1  1=zero-extend sub-word loads, 0=sign-extend.
- address  input  32  byte address.
- data_in  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- busy  output  1  high while an accepted access is in flight.
- done  output  1  one-cycle pulse when the access completes.
- data_out  output  32  load result; valid in the done cycle and held until the next done.
- err  output  1  one-cycle pulse, coincident with done, for a misaligned or illegal access.

Behaviour:
- Reset values: busy=0, done=0, err=0, data_out=0, FSM=IDLE, latency counter=0. Reset does not alter array contents unless DM_ZERO_INIT_EN is defined.
- Word index is address[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on req=1, latch mem_write, size, load_unsigned, address and data_in.
    - LATENCY=1: go to DONE.
    - Otherwise: load the counter with LATENCY-1 and go to WAIT.
  - WAIT: decrement the counter; go to DONE when it reaches 1.
  - DONE: done=1 for one cycle, then return to IDLE.
- busy=1 in WAIT and DONE. req is ignored while busy=1. The earliest next acceptance is the cycle after done.
- done rises exactly LATENCY cycles after the accepting edge.
- Error check (on latched values):
  - size=11 is illegal.
  - halfword with address[0]=1 is misaligned.
  - word with address[1:0]≠00 is misaligned.
  - On error: err=1 with done, no array write, data_out unchanged.
- Store commit: at the edge entering DONE, write only the addressed lanes.
  - byte → lane address[1:0].
  - half → lanes {address[1],0} and {address[1],1}.
  - word → all four lanes. Unaddressed lanes keep their old value.
- Load: at the edge entering DONE, data_out is loaded with the selected lane(s), shifted to bit 0, then extended per load_unsigned. Word loads ignore load_unsigned.
- Stores leave data_out unchanged.
- Reset asserted mid-access aborts it: no write is committed, and no done or err pulse is generated.

Optional Feature:
- Macro: DM_ZERO_INIT_EN.
- Defined: reset moves the FSM to a CLEAR state. After reset deasserts, one word per cycle is written to zero, from index 0 to DEPTH-1. busy stays 1 throughout, and IDLE is entered the cycle after the last word, i.e. DEPTH cycles after reset release. Reset during CLEAR restarts the sweep from index 0.
- Undefined: no CLEAR state. Array contents are unspecified after power-up and untouched by reset. busy=0 the first cycle after reset release.

Test Plan (DEPTH=1024, LATENCY=2):
- Word store 0xDEADBEEF at 0x10, then word load at 0x10 → done 2 cycles after each accept; busy high for 2 cycles; data_out=0xDEADBEEF; err=0.
- Byte store 0x80 at 0x13 over 0x11223344, then lb and lbu at 0x13 → word becomes 0x80223344; lb=0xFFFFFF80; lbu=0x00000080.
- Half store 0xBEEF at 0x22 over 0, then lh at 0x22 → word=0xBEEF0000; lh=0xFFFFBEEF. Lhu at 0x22 → 0x0000BEEF.
- Word store at 0x06 and size=11 load at 0x00 → err=1 with done each time; memory and data_out unchanged.
- req held high every cycle with mem_write=1 and alternating addresses → only one access per 3 cycles accepted. Address 0x1010 aliases 0x0010 (wrap).
- Reset asserted in the WAIT cycle of a store to 0x30 → no done pulse; a later load at 0x30 returns the old value. With DM_ZERO_INIT_EN, any address reads 0 after busy falls 1024 cycles post-reset.
